lsu_misalign_splitter: RTL and testbench
========================================

Name: lsu_misalign_splitter

Overview:
- Load/store sequencer directly upstream of the data memory; receives MEM-stage load/store requests (address, store data, funct3) and drives the DMEM single-port interface.
- Aligned accesses pass through in one cycle.
- Misaligned lh/lhu/lw become two aligned word reads plus a merge; misaligned sh/sw become a sequence of byte stores.
- The DMEM has one address port, so at most one DMEM access happens per cycle.

Parameters:
- WIDTH, 32, data/address width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1=store, 0=load
- req_addr  in  WIDTH  byte address
- req_wdata  in  WIDTH  store data
- req_funct3  in  3  RISC-V funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
- rsp_valid  out  1  one-cycle pulse, request complete
- rsp_rdata  out  WIDTH  extended load data; 0 for stores
- rsp_misaligned  out  1  misaligned-trap flag (see Optional Feature)
- dm_addr  out  WIDTH  DMEM byte address
- dm_MemWrite  out  1  DMEM write enable
- dm_MemRead  out  1  DMEM read enable
- dm_wdata  out  WIDTH  DMEM write data
- dm_control  out  3  DMEM funct3 control
- dm_rdata  in  WIDTH  DMEM asynchronous read data

Behaviour:
- Reset (async, rst_n low): state IDLE; rsp_valid=0, rsp_rdata=0, rsp_misaligned=0; all dm_* outputs 0; byte counter and latched request cleared.
- States: IDLE, LD2, ST.
- req_ready=1 only in IDLE. A request is accepted on req_valid & req_ready. Its fields are latched at acceptance; inputs outside the acceptance cycle are ignored.
- dm_* outputs are combinational from the request in IDLE and from latched fields in LD2/ST. They are 0 whenever no access occurs.
- Misaligned definition:
  - funct3 001/101 with addr[0]=1.
  - funct3 010 with addr[1:0]!=0.
  - Bytes are never misaligned.
  - Unsupported funct3 (011/110/111) is treated as aligned and forwarded unchanged.
- Aligned access:
  - Acceptance cycle drives dm_addr=req_addr, dm_control=req_funct3, dm_MemRead=!req_we, dm_MemWrite=req_we, dm_wdata=req_wdata.
  - dm_rdata is registered into rsp_rdata; rsp_valid pulses the next cycle.
  - Stays in IDLE.
- Misaligned load:
  - IDLE cycle: word read at {addr[31:2],2'b00}, control 010; result latched as w0. Go to LD2.
  - LD2 cycle: word read at ({addr[31:2],2'b00}+4), control 010, giving w1.
  - Merge: {w1,w0} >> (8*addr[1:0]), take low 16 (h) or 32 (w) bits; sign-extend for 001, zero-extend for 101. Register to rsp_rdata.
  - rsp_valid pulses next cycle; return to IDLE.
  - Latency is 2 cycles from acceptance.
- Misaligned store (N=2 for sh, N=4 for sw):
  - Byte k (0..N-1) is written to addr+k with control 000, dm_wdata[7:0]=req_wdata[8k+7:8k], upper bits 0.
  - Byte 0 is written in the IDLE cycle, bytes 1..N-1 in ST, one per cycle, using a 2-bit counter.
  - After the last byte, rsp_valid pulses with rsp_rdata=0, then return to IDLE.
  - req_ready is low for N-1 cycles.
- Address arithmetic is modulo 2^32. The second word or byte wraps: lw 0xFFFFFFFD reads 0xFFFFFFFC then 0x00000000.
- A new request may be accepted in the same cycle rsp_valid pulses for the previous one.
- Reset mid-operation: abort immediately, no rsp_valid. Bytes already stored remain in DMEM.
- dm_MemRead and dm_MemWrite are never asserted together.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: misaligned requests perform no DMEM access. rsp_valid and rsp_misaligned pulse the next cycle with rsp_rdata=0. LD2/ST are never entered.
- Undefined: splitting as above; rsp_misaligned is tied 0.

Test Plan:
- Preload DMEM: word0=0x44332211, word1=0x88776655, word2=0x000000CC.
- Aligned lw addr 0x4 -> single read, rsp_valid 1 cycle later, rsp_rdata=0x88776655, req_ready stays 1.
- lw addr 0x1 -> reads at 0x0 then 0x4, rsp_rdata=0x55443322, rsp_valid 2 cycles after acceptance.
- lh addr 0x7 -> rsp_rdata=0xFFFFCC88; lhu addr 0x7 -> 0x0000CC88.
- sw 0xDEADBEEF addr 0x2 -> sb at 0x2,0x3,0x4,0x5 with bytes EF,BE,AD,DE; word0=0xBEEF2211, word1=0x8877DEAD; req_ready low 3 cycles.
- Same sw with rst_n pulsed low during the byte-2 write -> immediate IDLE, all outputs 0, no rsp_valid; word0=0xBEEF2211.
- With MISALIGN_TRAP_EN: lw addr 0x1 -> no dm_MemRead, next cycle rsp_valid=1, rsp_misaligned=1, rsp_rdata=0.

Source files
------------

// File: rtl/lsu_misalign_splitter.sv
`default_nettype none
// ============================================================================
// Module   : lsu_misalign_splitter
// Brief    : Load/store sequencer in front of a single-port data memory.
//            Aligned accesses pass straight through. Misaligned halfword/word
//            loads become two aligned word reads plus a merge. Misaligned
//            halfword/word stores become a run of byte stores.
//            Optional build macro MISALIGN_TRAP_EN: misaligned requests make
//            no memory access and are answered with rsp_misaligned instead.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_misalign_splitter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [2:0]       req_funct3,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_misaligned,
    output logic [WIDTH-1:0] dm_addr,
    output logic             dm_MemWrite,
    output logic             dm_MemRead,
    output logic [WIDTH-1:0] dm_wdata,
    output logic [2:0]       dm_control,
    input  logic [WIDTH-1:0] dm_rdata
);

    localparam logic [2:0] F3_B = 3'b000;
    localparam logic [2:0] F3_H = 3'b001;
    localparam logic [2:0] F3_W = 3'b010;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LD2  = 2'd1,
        S_ST   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [WIDTH-1:0] w0_q, w0_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef MISALIGN_TRAP_EN
    logic             rsp_mis_q, rsp_mis_d;
`endif

    logic             req_mis;
    logic [WIDTH-1:0] req_word_base;
    logic [WIDTH-1:0] lat_word_base;
    logic [WIDTH-1:0] merged;
    logic [1:0]       last_idx;

    // A request is misaligned when a halfword is odd or a word is not on a
    // 4-byte boundary; bytes and unsupported encodings never are.
    assign req_mis = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0])
                   || ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));

    assign req_word_base = {req_addr[WIDTH-1:2], 2'b00};
    assign lat_word_base = {addr_q[WIDTH-1:2], 2'b00};

    // Second word on top of the first, shifted down by the byte offset,
    // leaves the requested bytes in the low bits.
    assign merged = WIDTH'({dm_rdata, w0_q} >> {addr_q[1:0], 3'b000});

    // Index of the final byte of a split store: 1 for sh, 3 for sw.
    assign last_idx = (funct3_q == F3_W) ? 2'd3 : 2'd1;

    // State register and latched request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= 3'b000;
            w0_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
            rsp_mis_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            w0_q        <= w0_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef MISALIGN_TRAP_EN
            rsp_mis_q   <= rsp_mis_d;
`endif
        end
    end

    // Next-state, DMEM drive and response computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        w0_d        = w0_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
`ifdef MISALIGN_TRAP_EN
        rsp_mis_d   = 1'b0;
`endif
        req_ready   = 1'b0;
        dm_addr     = '0;
        dm_MemWrite = 1'b0;
        dm_MemRead  = 1'b0;
        dm_wdata    = '0;
        dm_control  = 3'b000;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    funct3_d = req_funct3;
                    cnt_d    = 2'd0;
                    if (!req_mis) begin
                        // Aligned: one pass-through access, answer next cycle.
                        dm_addr     = req_addr;
                        dm_control  = req_funct3;
                        dm_MemRead  = !req_we;
                        dm_MemWrite = req_we;
                        dm_wdata    = req_wdata;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = req_we ? '0 : dm_rdata;
                    end else begin
`ifdef MISALIGN_TRAP_EN
                        // Trap: no memory traffic, just flag the request.
                        rsp_valid_d = 1'b1;
                        rsp_mis_d   = 1'b1;
`else
                        if (!req_we) begin
                            // First of two aligned word reads.
                            dm_addr    = req_word_base;
                            dm_control = F3_W;
                            dm_MemRead = 1'b1;
                            w0_d       = dm_rdata;
                            state_d    = S_LD2;
                        end else begin
                            // Byte 0 of the split store goes out immediately.
                            dm_addr     = req_addr;
                            dm_control  = F3_B;
                            dm_MemWrite = 1'b1;
                            dm_wdata    = {{(WIDTH-8){1'b0}}, req_wdata[7:0]};
                            cnt_d       = 2'd1;
                            state_d     = S_ST;
                        end
`endif
                    end
                end
            end

            S_LD2: begin
                // Second word read (wraps modulo 2^WIDTH), then merge/extend.
                dm_addr     = lat_word_base + WIDTH'(4);
                dm_control  = F3_W;
                dm_MemRead  = 1'b1;
                rsp_valid_d = 1'b1;
                if (funct3_q == F3_W) begin
                    rsp_rdata_d = merged;
                end else begin
                    rsp_rdata_d = {{(WIDTH-16){merged[15] & ~funct3_q[2]}}, merged[15:0]};
                end
                state_d = S_IDLE;
            end

            S_ST: begin
                dm_addr     = addr_q + WIDTH'(cnt_q);
                dm_control  = F3_B;
                dm_MemWrite = 1'b1;
                dm_wdata    = {{(WIDTH-8){1'b0}}, wdata_q[8*cnt_q +: 8]};
                if (cnt_q == last_idx) begin
                    rsp_valid_d = 1'b1;
                    cnt_d       = 2'd0;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef MISALIGN_TRAP_EN
    assign rsp_misaligned = rsp_mis_q;
`else
    assign rsp_misaligned = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_misalign_splitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_misalign_splitter
// Brief    : Scoreboard bench for lsu_misalign_splitter with a byte-array
//            DMEM and a byte-level reference model. Honours MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_misalign_splitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = 3'b000;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic [31:0] dm_addr;
    logic        dm_MemWrite;
    logic        dm_MemRead;
    logic [31:0] dm_wdata;
    logic [2:0]  dm_control;
    logic [31:0] dm_rdata;

    lsu_misalign_splitter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_misaligned(rsp_misaligned),
        .dm_addr(dm_addr), .dm_MemWrite(dm_MemWrite), .dm_MemRead(dm_MemRead),
        .dm_wdata(dm_wdata), .dm_control(dm_control), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DMEM model (256 bytes, address modulo 256) ----------
    logic [7:0] dmem [256];
    logic [7:0] ref_mem [256];
    logic       do_preload = 1'b0;

    function automatic logic [7:0] img(int i);
        case (i)
            0: img = 8'h11; 1: img = 8'h22; 2: img = 8'h33; 3: img = 8'h44;
            4: img = 8'h55; 5: img = 8'h66; 6: img = 8'h77; 7: img = 8'h88;
            8: img = 8'hCC;
            default: img = 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < 256; i++) dmem[i] <= img(i);
        end else if (dm_MemWrite) begin
            case (dm_control)
                3'b000: dmem[dm_addr[7:0]] <= dm_wdata[7:0];
                3'b001: begin
                    dmem[dm_addr[7:0]]         <= dm_wdata[7:0];
                    dmem[dm_addr[7:0] + 8'd1]  <= dm_wdata[15:8];
                end
                3'b010: begin
                    dmem[dm_addr[7:0]]         <= dm_wdata[7:0];
                    dmem[dm_addr[7:0] + 8'd1]  <= dm_wdata[15:8];
                    dmem[dm_addr[7:0] + 8'd2]  <= dm_wdata[23:16];
                    dmem[dm_addr[7:0] + 8'd3]  <= dm_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        logic [7:0] a;
        a = dm_addr[7:0];
        dm_rdata = '0;
        if (dm_MemRead) begin
            case (dm_control)
                3'b000: dm_rdata = {{24{dmem[a][7]}}, dmem[a]};
                3'b100: dm_rdata = {24'h0, dmem[a]};
                3'b001: dm_rdata = {{16{dmem[a + 8'd1][7]}}, dmem[a + 8'd1], dmem[a]};
                3'b101: dm_rdata = {16'h0, dmem[a + 8'd1], dmem[a]};
                3'b010: dm_rdata = {dmem[a + 8'd3], dmem[a + 8'd2], dmem[a + 8'd1], dmem[a]};
                default: dm_rdata = '0;
            endcase
        end
    end

    function automatic logic [31:0] mem_word(int base);
        mem_word = {dmem[base + 3], dmem[base + 2], dmem[base + 1], dmem[base]};
    endfunction

    // ---------------- Scoreboard ------------------------------------------
    typedef struct {
        logic [31:0] rd;
        logic        mis;
        int          due;
    } exp_t;
    exp_t sbq[$];

    // Monitor: every response is popped and compared with the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                checks++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL rsp_unexpected: rsp_valid=1 rdata=%h with nothing outstanding", rsp_rdata);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (rsp_rdata !== e.rd || rsp_misaligned !== e.mis || cyc != e.due) begin
                        fails++;
                        $display("FAIL rsp: got rdata=%h mis=%b cyc=%0d, want rdata=%h mis=%b cyc=%0d",
                                 rsp_rdata, rsp_misaligned, cyc, e.rd, e.mis, e.due);
                    end
                end
            end
            if (dm_MemRead || dm_MemWrite) begin
                checks++;
                if (dm_MemRead && dm_MemWrite) begin
                    fails++;
                    $display("FAIL rd_wr_excl: MemRead=1 MemWrite=1 at cyc %0d, want not both", cyc);
                end
            end
        end
    end

    // ---------------- Reference model -------------------------------------
    function automatic int size_of(input logic [2:0] f3);
        size_of = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic is_mis(input logic [31:0] addr, input logic [2:0] f3);
        is_mis = (addr & (size_of(f3) - 1)) != 0;
    endfunction

    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, output logic [31:0] rd, output logic mis,
                         output int lat);
        int n;
        logic [31:0] v;
        n   = size_of(f3);
        mis = 1'b0;
        rd  = '0;
        lat = 1;
`ifdef MISALIGN_TRAP_EN
        if (is_mis(addr, f3)) begin
            mis = 1'b1;
            return;
        end
`endif
        if (we) begin
            for (int k = 0; k < n; k++) ref_mem[addr[7:0] + 8'(k)] = wdata[8*k +: 8];
            lat = is_mis(addr, f3) ? n : 1;
        end else begin
            v = '0;
            for (int k = 0; k < n; k++) v = v | (32'(ref_mem[addr[7:0] + 8'(k)]) << (8*k));
            if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            rd  = v;
            lat = is_mis(addr, f3) ? 2 : 1;
        end
    endtask

    // ---------------- Driver ----------------------------------------------
    // Called at a negedge; returns at a negedge with req_ready high.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3);
        int guard, lowc, c, lat;
        logic [31:0] rd, ex_addr;
        logic mis, ex_rd, ex_wr;
        exp_t e;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        guard = 0;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) begin
            fails++; checks++;
            $display("FAIL ready_timeout: req_ready stuck 0 for %0d cycles", guard);
        end
        // First DMEM access of this request, derived from the address rules.
        #1;
        ex_addr = addr; ex_rd = !we; ex_wr = we;
        if (is_mis(addr, f3)) begin
`ifdef MISALIGN_TRAP_EN
            ex_addr = '0; ex_rd = 1'b0; ex_wr = 1'b0;
`else
            if (!we) ex_addr = {addr[31:2], 2'b00};
`endif
        end
        checks++;
        if (dm_addr !== ex_addr || dm_MemRead !== ex_rd || dm_MemWrite !== ex_wr) begin
            fails++;
            $display("FAIL first_access: got addr=%h rd=%b wr=%b, want addr=%h rd=%b wr=%b",
                     dm_addr, dm_MemRead, dm_MemWrite, ex_addr, ex_rd, ex_wr);
        end
        @(posedge clk); #1;
        c = cyc;
        model(we, addr, wdata, f3, rd, mis, lat);
        e.rd = rd; e.mis = mis; e.due = c + lat - 1;
        sbq.push_back(e);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_we = $urandom_range(0, 1);
        lowc = 0;
        @(negedge clk);
        while (!req_ready && lowc < 10) begin lowc++; @(negedge clk); end
        checks++;
        if (lowc != lat - 1) begin
            fails++;
            $display("FAIL ready_low: req_ready low %0d cycles, want %0d", lowc, lat - 1);
        end
    endtask

    task automatic load_image();
        do_preload = 1'b1;
        @(posedge clk); #1;
        do_preload = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = img(i);
        @(negedge clk);
    endtask

    // ---------------- Main sequence ---------------------------------------
    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          guard;

        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_misaligned !== 1'b0 ||
            dm_addr !== 32'h0 || dm_MemRead !== 1'b0 || dm_MemWrite !== 1'b0 ||
            dm_wdata !== 32'h0 || dm_control !== 3'b000 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: rsp_v=%b rdata=%h dm_addr=%h rd=%b wr=%b ready=%b, want zeros and ready=1",
                     rsp_valid, rsp_rdata, dm_addr, dm_MemRead, dm_MemWrite, req_ready);
        end
        load_image();
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases from the memory image.
        issue(1'b0, 32'h4, 32'h0, 3'b010);
        issue(1'b0, 32'h1, 32'h0, 3'b010);
        issue(1'b0, 32'h7, 32'h0, 3'b001);
        issue(1'b0, 32'h7, 32'h0, 3'b101);
        issue(1'b1, 32'h2, 32'hDEADBEEF, 3'b010);
`ifndef MISALIGN_TRAP_EN
        checks++;
        if (mem_word(0) !== 32'hBEEF2211 || mem_word(4) !== 32'h8877DEAD) begin
            fails++;
            $display("FAIL sw_split: word0=%h word1=%h, want BEEF2211 8877DEAD", mem_word(0), mem_word(4));
        end

        // Reset during the byte-2 write of a split word store.
        load_image();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h2; req_wdata = 32'hDEADBEEF; req_funct3 = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (dm_MemWrite !== 1'b1 || dm_addr !== 32'h4 || dm_wdata !== 32'h000000AD) begin
            fails++;
            $display("FAIL byte2_drive: wr=%b addr=%h wdata=%h, want 1 00000004 000000AD",
                     dm_MemWrite, dm_addr, dm_wdata);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || dm_addr !== 32'h0 || dm_MemRead !== 1'b0 ||
            dm_MemWrite !== 1'b0 || dm_wdata !== 32'h0 || dm_control !== 3'b000) begin
            fails++;
            $display("FAIL mid_reset: rsp_v=%b dm_addr=%h rd=%b wr=%b wdata=%h, want all 0",
                     rsp_valid, dm_addr, dm_MemRead, dm_MemWrite, dm_wdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ref_mem[2] = 8'hEF; ref_mem[3] = 8'hBE;
        checks++;
        if (mem_word(0) !== 32'hBEEF2211 || mem_word(4) !== 32'h88776655) begin
            fails++;
            $display("FAIL reset_abort_mem: word0=%h word1=%h, want BEEF2211 88776655", mem_word(0), mem_word(4));
        end
        @(negedge clk);
`endif

        // Wrap-around cases.
        issue(1'b0, 32'hFFFFFFFD, 32'h0, 3'b010);
        issue(1'b1, 32'hFFFFFFFF, 32'hA5C3, 3'b001);
        issue(1'b0, 32'hFFFFFFFF, 32'h0, 3'b101);

        // Randomised traffic with idle gaps and garbage on unaccepted inputs.
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: f3 = 3'b000;
                1: f3 = 3'b001;
                2: f3 = 3'b010;
                3: f3 = we ? 3'b010 : 3'b100;
                default: f3 = we ? 3'b001 : 3'b101;
            endcase
            if ($urandom_range(0, 3) == 0) addr = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            else addr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom_range(0, 7));
                    @(negedge clk);
                end
            end
            issue(we, addr, $urandom, f3);
        end

        guard = 0;
        while (sbq.size() != 0 && guard < 100) begin @(negedge clk); guard++; end
        checks++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d responses outstanding, want 0", sbq.size());
        end

        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 256; i++) if (dmem[i] !== ref_mem[i]) bad++;
            checks++;
            if (bad != 0) begin
                fails++;
                $display("FAIL mem_final: %0d bytes differ from model, want 0", bad);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
